// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle; results land in HI/LO on leaving FINISH.
module mul_div_unit #(
  parameter int DATA_W = 32,
  parameter int ITER   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Start,
  input  logic [2:0]        MDOp,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic [1:0]        dbg_state
);

  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d;     // product / quotient must be negated
  logic              rneg_q, rneg_d;   // remainder must be negated
  logic              bz_q, bz_d;       // divisor was zero: skip sign correction
  logic [DATA_W-1:0] opb_q, opb_d;     // multiplicand or divisor magnitude
  logic [DATA_W-1:0] acc_q, acc_d;     // product high half or partial remainder
  logic [DATA_W-1:0] wrk_q, wrk_d;     // multiplier / dividend, shifted each step
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              done_q, done_d;

  logic              sgn;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] diff;
  logic [2*DATA_W-1:0] prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    bz_d     = bz_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    wrk_d    = wrk_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    sgn   = ~MDOp[0];
    abs_a = (sgn && SrcA[DATA_W-1]) ? -SrcA : SrcA;
    abs_b = (sgn && SrcB[DATA_W-1]) ? -SrcB : SrcB;
    sum   = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opb_q} : '0);
    trial = {acc_q, wrk_q[DATA_W-1]};
    diff  = trial[DATA_W-1:0] - opb_q;
    prod  = {acc_q, wrk_q};

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (!MDOp[2]) begin
            state_d  = S_RUN;
            cnt_d    = '0;
            is_div_d = MDOp[1];
            neg_d    = sgn & (SrcA[DATA_W-1] ^ SrcB[DATA_W-1]);
            rneg_d   = sgn & SrcA[DATA_W-1];
            bz_d     = (SrcB == '0);
            acc_d    = '0;
            wrk_d    = MDOp[1] ? abs_a : abs_b;
            opb_d    = MDOp[1] ? abs_b : abs_a;
          end else if (MDOp == 3'b100) begin
            hi_d = SrcA;
          end else if (MDOp == 3'b101) begin
            lo_d = SrcA;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          // Restoring step: keep the subtraction only when it does not borrow.
          if (trial >= {1'b0, opb_q}) begin
            acc_d = diff;
            wrk_d = {wrk_q[DATA_W-2:0], 1'b1};
          end else begin
            acc_d = trial[DATA_W-1:0];
            wrk_d = {wrk_q[DATA_W-2:0], 1'b0};
          end
        end else begin
          acc_d = sum[DATA_W:1];
          wrk_d = {sum[0], wrk_q[DATA_W-1:1]};
        end
        if (cnt_q == CW'(ITER - 1)) state_d = S_FINISH;
      end
      S_FINISH: begin
        if (is_div_q) begin
          lo_d = (neg_q && !bz_q) ? -wrk_q : wrk_q;
          hi_d = (rneg_q && !bz_q) ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = neg_q ? -prod : prod;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bz_q     <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      wrk_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      bz_q     <= bz_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      wrk_q    <= wrk_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Done      = done_q;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: expected HI/LO pairs queued at issue,
// popped and compared by a monitor whenever Done is presented.
module tb_mul_div_unit;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] SrcA, SrcB;
  logic        Busy, Done;
  logic [31:0] HI, LO;
  logic [1:0]  dbg_state;

  logic [63:0] exp_q[$];
  logic [31:0] hi_m, lo_m;
  int          n_checks;
  int          n_fail;

  mul_div_unit #(.DATA_W(32), .ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .MDOp(MDOp),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done),
    .HI(HI), .LO(LO), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // monitor: every Done pulse must match the oldest queued result
  always @(negedge clk) begin
    if (rst_n === 1'b1 && Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        check("hi_lo_result", {HI, LO}, exp_q.pop_front());
      end
    end
  end

  // driver: issue one mult/div, watch the busy window, optionally poke Start mid-run
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input bit inject);
    bit ok;
    exp_q.push_back({eh, el});
    Start = 1'b1; MDOp = op; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    Start = 1'b0;
    SrcA = $urandom; SrcB = $urandom; MDOp = 3'($urandom_range(0, 7));
    ok = 1'b1;
    for (int c = 0; c < 33; c++) begin
      if (Busy !== 1'b1 || Done !== 1'b0 || HI !== hi_m || LO !== lo_m) ok = 1'b0;
      if (inject && c == 5) begin
        Start = 1'b1; MDOp = 3'b100; SrcA = 32'hDEADBEEF;
      end
      @(posedge clk); #1;
      Start = 1'b0;
    end
    check("busy_window_hold", {63'd0, ok}, 64'd1);
    check("finish_busy_done", {62'd0, Busy, Done}, 64'd1);
    hi_m = eh; lo_m = el;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    hi_m = '0; lo_m = '0;
    rst_n = 1'b0; Start = 1'b0; MDOp = '0; SrcA = '0; SrcB = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {HI, LO}, 64'd0);
    check("reset_flags", {62'd0, Busy, Done}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    // issued in the Done cycle of the previous op
    run_op(3'b000, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0);
    run_op(3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    run_op(3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op(3'b010, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_op(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op(3'b011, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, 1'b0);

    // MTHI then MTLO on consecutive idle edges
    Start = 1'b1; MDOp = 3'b100; SrcA = 32'hAAAA5555;
    @(posedge clk); #1;
    check("mthi", {HI, LO}, {32'hAAAA5555, lo_m});
    check("mthi_flags", {62'd0, Busy, Done}, 64'd0);
    MDOp = 3'b101; SrcA = 32'h0F0F0F0F;
    @(posedge clk); #1;
    check("mtlo", {HI, LO}, {32'hAAAA5555, 32'h0F0F0F0F});
    check("mtlo_flags", {62'd0, Busy, Done}, 64'd0);
    hi_m = 32'hAAAA5555; lo_m = 32'h0F0F0F0F;
    MDOp = 3'b110; SrcA = 32'h12345678;
    @(posedge clk); #1;
    Start = 1'b0;
    check("noop_op", {HI, LO}, {hi_m, lo_m});
    check("noop_flags", {62'd0, Busy, Done}, 64'd0);

    // MTHI during RUN must be ignored
    run_op(3'b001, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b1);
    @(posedge clk); #1;

    // async reset mid-run discards the operation
    Start = 1'b1; MDOp = 3'b000; SrcA = 32'd3; SrcB = 32'd4;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_hi_lo", {HI, LO}, 64'd0);
    check("abort_flags", {62'd0, Busy, Done}, 64'd0);
    hi_m = '0; lo_m = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(3'b000, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers. It sits beside the combinational ALU in the multicycle datapath.
- Executes the operations the single-cycle ALU cannot: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- The control FSM issues a one-cycle Start and stalls on Busy. MFHI/MFLO read HI/LO directly.

Parameters:
- DATA_W, 32, operand/HI/LO width. Only 32 is required to be supported.
- ITER, 32, iterations per mult/div (one bit per cycle). Must equal DATA_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Start  input  1  request, sampled on rising edge
- MDOp  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op
- SrcA  input  DATA_W  rs operand (multiplicand/dividend; MTHI/MTLO source)
- SrcB  input  DATA_W  rt operand (multiplier/divisor)
- Busy  output  1  iterative operation in progress
- Done  output  1  one-cycle pulse: HI/LO just updated by mult/div
- HI  output  DATA_W  HI register (product high / remainder)
- LO  output  DATA_W  LO register (product low / quotient)

Behaviour:
- Reset (rst_n=0, asynchronous): HI=0, LO=0, Busy=0, Done=0, FSM=IDLE, iteration counter=0, working registers=0.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - Start=1 with MDOp in 000–011: latch operands and op, counter=0, go to RUN. Busy=1 from the following cycle.
  - Start=1 with MDOp 100: HI<=SrcA at that edge. Stay IDLE; Busy and Done stay 0.
  - Start=1 with MDOp 101: LO<=SrcA at that edge. Stay IDLE; Busy and Done stay 0.
  - Start=1 with MDOp 110/111: ignored.
- Signed ops (MULT, DIV):
  - Latch |SrcA| and |SrcB| as unsigned magnitudes, plus the result sign flags.
  - Quotient/product sign = signA XOR signB; remainder sign = signA.
  - |0x80000000| = 0x80000000 as unsigned.
- Unsigned ops: latch operands directly, sign flags cleared.
- RUN: one iteration per cycle, counter increments, ITER cycles total.
  - Multiply: 64-bit shift-add, LSB-first on the multiplier.
  - Divide: restoring, MSB-first, 33-bit partial remainder.
  - After the ITER-th iteration, go to FINISH.
- FINISH (one cycle):
  - Apply sign correction (two's complement negate where the flag is set).
  - Write HI/LO at the edge leaving FINISH; go to IDLE.
  - Busy=0 and Done=1 for exactly the cycle after that edge.
- Latency: accept edge E0, then RUN on E1..E32, FINISH ends at E33. Busy is high during cycles E0..E33; HI/LO are new and Busy=0 after E33. MTHI/MTLO latency is 0 cycles.
- Start while Busy=1: ignored, including MTHI/MTLO. HI/LO are unchanged until FINISH. Operand changes during RUN have no effect.
- HI/LO hold their previous values throughout RUN. No partial results are visible.
- Divide by zero (SrcB=0): full latency. LO=0xFFFFFFFF, HI=SrcA as latched. The signed case gives the same pattern with no sign correction applied.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- rst_n asserted mid-RUN: immediate abort to reset values. HI/LO are cleared and the result is lost.
- Start in the cycle Done=1: accepted normally (back-to-back issue).

Test Plan:
- MULT SrcA=0xFFFFFFFD (-3), SrcB=5 -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1. Busy high during cycles E0..E33. Done pulses once.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. A second MULT issued on the Done cycle gives the correct result 34 cycles later.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x1234/0 -> LO=0xFFFFFFFF, HI=0x1234 after full latency.
- MTHI 0xAAAA5555 then MTLO 0x0F0F0F0F in consecutive idle cycles -> HI/LO updated on the same edges, Busy and Done stay 0. MTHI issued during a RUN -> HI unchanged.
- Start MULT 3*4, assert rst_n=0 at cycle 10 -> HI=LO=0 and Busy=0 immediately. After release, MULT 3*4 -> LO=12, HI=0.
